element_read_arbiter: RTL and testbench

- Shares one single-port element memory (read-only, fixed read latency) between the two read streams of the dual vector constructor: first stream = requester 0, second stream = requester 1.
- Grants one read per cycle using round-robin, issues a registered memory read, and steers the returned element back to the requester that owns it.
- Sits between the constructor's first_addr/second_addr outputs and the element BRAM. Supports a flush for job restart.

---
 rtl/element_read_arbiter.sv | 111 +++++++++++
 tb/tb_element_read_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/element_read_arbiter.sv
// Round-robin arbiter that shares one fixed-latency, read-only element memory
// between the two read streams of the dual vector constructor.
module element_read_arbiter #(
    parameter int ELEMENT_WIDTH = 24,
    parameter int ADDR_WIDTH    = 17,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req0,
    input  logic [ADDR_WIDTH-1:0]    addr0,
    output logic                     gnt0,
    output logic [ELEMENT_WIDTH-1:0] data0,
    output logic                     valid0,
    input  logic                     req1,
    input  logic [ADDR_WIDTH-1:0]    addr1,
    output logic                     gnt1,
    output logic [ELEMENT_WIDTH-1:0] data1,
    output logic                     valid1,
    output logic                     mem_en,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_data,
    output logic                     busy
);

    logic                  rr_ptr;
    logic                  grant_any;
    logic [READ_LATENCY:0] tag_valid;
    logic [READ_LATENCY:0] tag_owner;

    // On a tie the requester that did not win last time gets the memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset && !flush) begin
            if (req0 && req1) begin
                gnt0 = rr_ptr;
                gnt1 = !rr_ptr;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign grant_any = gnt0 | gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b1;
        end else if (flush) begin
            rr_ptr <= 1'b1;
        end else if (gnt0) begin
            rr_ptr <= 1'b0;
        end else if (gnt1) begin
            rr_ptr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_en <= grant_any;
            if (grant_any) begin
                mem_addr <= gnt1 ? addr1 : addr0;
            end
        end
    end

    // The owner tag travels alongside the read so that slot READ_LATENCY
    // lines up with the cycle in which mem_data is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else if (flush) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid <= {tag_valid[READ_LATENCY-1:0], grant_any};
            tag_owner <= {tag_owner[READ_LATENCY-1:0], gnt1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data0  <= '0;
            data1  <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (!flush && tag_valid[READ_LATENCY]) begin
                if (tag_owner[READ_LATENCY]) begin
                    data1  <= mem_data;
                    valid1 <= 1'b1;
                end else begin
                    data0  <= mem_data;
                    valid0 <= 1'b1;
                end
            end
        end
    end

    assign busy = mem_en | (|tag_valid);

endmodule

// File: tb/tb_element_read_arbiter.sv
// Bench for element_read_arbiter: instances with READ_LATENCY 1, 2 and 8 share one
// stimulus stream; a queue-based model predicts grants, issues and returns.
`timescale 1ns/1ps
module tb_element_read_arbiter;
    localparam int AW = 17;
    localparam int EW = 24;
    localparam int N  = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;

    logic          gnt0_w [N];
    logic          gnt1_w [N];
    logic          valid0_w [N];
    logic          valid1_w [N];
    logic          mem_en_w [N];
    logic          busy_w [N];
    logic [AW-1:0] mem_addr_w [N];
    logic [EW-1:0] data0_w [N];
    logic [EW-1:0] data1_w [N];
    logic [EW-1:0] mem_data_w [N];

    logic [EW-1:0] mem [1024];

    int checks = 0;
    int passed = 0;
    int cnt    = 0;

    typedef struct {
        int            due;
        int            k;
        logic          own;
        logic [EW-1:0] d;
    } ret_t;

    ret_t          q [$];
    logic          rr_last = 1'b1;
    logic          exp_mem_en = 1'b0;
    logic [AW-1:0] exp_mem_addr = '0;
    logic          exp_v0 [N];
    logic          exp_v1 [N];
    logic [EW-1:0] exp_d0 [N];
    logic [EW-1:0] exp_d1 [N];

    always #5 clk = ~clk;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 8;
    endfunction

    // Returns {gnt1, gnt0}; rr is the index that won the previous grant.
    function automatic logic [1:0] rr_pick(input logic r0, input logic r1, input logic f,
                                           input logic rst_n, input logic rr);
        if (!rst_n || f) return 2'b00;
        if (r0 && r1) return rr ? 2'b01 : 2'b10;
        return {r1, r0};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_lat
        localparam int L = (k == 0) ? 1 : (k == 1) ? 2 : 8;
        logic [AW-1:0] pipe_addr [L];
        logic [L-1:0]  pipe_en;

        element_read_arbiter #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
            .clk(clk), .reset(reset), .flush(flush),
            .req0(req0), .addr0(addr0), .gnt0(gnt0_w[k]), .data0(data0_w[k]), .valid0(valid0_w[k]),
            .req1(req1), .addr1(addr1), .gnt1(gnt1_w[k]), .data1(data1_w[k]), .valid1(valid1_w[k]),
            .mem_en(mem_en_w[k]), .mem_addr(mem_addr_w[k]), .mem_data(mem_data_w[k]),
            .busy(busy_w[k]));

        always @(posedge clk) begin
            pipe_en[0]   <= mem_en_w[k];
            pipe_addr[0] <= mem_addr_w[k];
            for (int i = 1; i < L; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end

        assign mem_data_w[k] = pipe_en[L-1] ? mem[pipe_addr[L-1][9:0]] : 24'hEEEEEE;
    end

    // Reference model: every grant becomes one pending return per latency build.
    initial begin : model
        logic [1:0] pick;
        ret_t       e;
        for (int k = 0; k < N; k++) begin
            exp_v0[k] = 1'b0; exp_v1[k] = 1'b0; exp_d0[k] = '0; exp_d1[k] = '0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                rr_last      = 1'b1;
                exp_mem_en   = 1'b0;
                exp_mem_addr = '0;
                for (int k = 0; k < N; k++) begin
                    exp_v0[k] = 1'b0; exp_v1[k] = 1'b0; exp_d0[k] = '0; exp_d1[k] = '0;
                end
            end else begin
                cnt++;
                for (int k = 0; k < N; k++) begin
                    exp_v0[k] = 1'b0; exp_v1[k] = 1'b0;
                end
                pick = rr_pick(req0, req1, flush, reset, rr_last);
                if (flush) begin
                    q.delete();
                    rr_last = 1'b1;
                end else begin
                    for (int i = q.size() - 1; i >= 0; i--) begin
                        if (q[i].due == cnt) begin
                            if (q[i].own) begin
                                exp_v1[q[i].k] = 1'b1; exp_d1[q[i].k] = q[i].d;
                            end else begin
                                exp_v0[q[i].k] = 1'b1; exp_d0[q[i].k] = q[i].d;
                            end
                            q.delete(i);
                        end
                    end
                end
                exp_mem_en = (pick != 2'b00);
                if (pick != 2'b00) begin
                    exp_mem_addr = pick[1] ? addr1 : addr0;
                    rr_last      = pick[1];
                    for (int k = 0; k < N; k++) begin
                        e.due = cnt + 1 + lat(k);
                        e.k   = k;
                        e.own = pick[1];
                        e.d   = mem[exp_mem_addr[9:0]];
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Drives inputs 2ns after a rising edge and returns 6ns after it.
    task automatic step(input int r0, input int a0, input int r1, input int a1, input int f);
        @(posedge clk);
        #2;
        req0  = (r0 != 0);
        addr0 = AW'(a0);
        req1  = (r1 != 0);
        addr1 = AW'(a1);
        flush = (f != 0);
        #4;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        step(1, 5, 1, 7, 0);
        step(1, 5, 1, 7, 0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({gnt0_w[k], gnt1_w[k], mem_en_w[k], valid0_w[k], valid1_w[k], busy_w[k]} !== 6'b0)
                $display("FAIL reset_ctrl k=%0d: got %b expected 000000", k,
                         {gnt0_w[k], gnt1_w[k], mem_en_w[k], valid0_w[k], valid1_w[k], busy_w[k]});
            else passed++;
            checks++;
            if ({mem_addr_w[k], data0_w[k], data1_w[k]} !== '0)
                $display("FAIL reset_data k=%0d: got addr %h d0 %h d1 %h expected 0", k,
                         mem_addr_w[k], data0_w[k], data1_w[k]);
            else passed++;
        end
        step(0, 0, 0, 0, 0);
        #1 reset = 1'b1;
    endtask

    task automatic test_contention();
        for (int c = 0; c < 20; c++) begin
            step(c < 6 ? 1 : 0, c / 2, c < 6 ? 1 : 0, 100 + c / 2, 0);
            for (int k = 0; k < N; k++) begin
                int            g;
                logic          ev0;
                logic          ev1;
                logic [AW-1:0] ea;
                if (c < 6) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k]} !== ((c % 2 == 1) ? 2'b10 : 2'b01))
                        $display("FAIL cont_gnt k=%0d c=%0d: got %b", k, c, {gnt1_w[k], gnt0_w[k]});
                    else passed++;
                end
                if (c >= 1 && c <= 6) begin
                    g  = c - 1;
                    ea = (g % 2 == 1) ? AW'(100 + g / 2) : AW'(g / 2);
                    checks++;
                    if ({mem_en_w[k], mem_addr_w[k]} !== {1'b1, ea})
                        $display("FAIL cont_issue k=%0d c=%0d: got en %b addr %0d expected addr %0d",
                                 k, c, mem_en_w[k], mem_addr_w[k], ea);
                    else passed++;
                end
                g   = c - 2 - lat(k);
                ev0 = (g >= 0 && g < 6 && g % 2 == 0);
                ev1 = (g >= 0 && g < 6 && g % 2 == 1);
                checks++;
                if ({valid1_w[k], valid0_w[k]} !== {ev1, ev0})
                    $display("FAIL cont_valid k=%0d c=%0d: got %b expected %b", k, c,
                             {valid1_w[k], valid0_w[k]}, {ev1, ev0});
                else passed++;
                if (ev0) begin
                    checks++;
                    if (data0_w[k] !== mem[g / 2])
                        $display("FAIL cont_data0 k=%0d c=%0d: got %h expected %h", k, c, data0_w[k], mem[g / 2]);
                    else passed++;
                end
                if (ev1) begin
                    checks++;
                    if (data1_w[k] !== mem[100 + g / 2])
                        $display("FAIL cont_data1 k=%0d c=%0d: got %h expected %h", k, c, data1_w[k], mem[100 + g / 2]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 14; c++) begin
            step(c == 0 ? 1 : 0, 5, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                if (c == 0) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k]} !== 2'b01)
                        $display("FAIL single_gnt k=%0d: got %b expected 01", k, {gnt1_w[k], gnt0_w[k]});
                    else passed++;
                end
                if (c == 1) begin
                    checks++;
                    if ({mem_en_w[k], mem_addr_w[k]} !== {1'b1, AW'(5)})
                        $display("FAIL single_issue k=%0d: got en %b addr %0d expected 1/5", k, mem_en_w[k], mem_addr_w[k]);
                    else passed++;
                end
                checks++;
                if ({valid1_w[k], valid0_w[k]} !== {1'b0, c == 2 + lat(k)})
                    $display("FAIL single_valid k=%0d c=%0d: got %b", k, c, {valid1_w[k], valid0_w[k]});
                else passed++;
                if (c >= 2 + lat(k)) begin
                    checks++;
                    if (data0_w[k] !== 24'h00ABCD)
                        $display("FAIL single_data k=%0d c=%0d: got %h expected 00abcd", k, c, data0_w[k]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_fairness();
        int gown [3]  = '{1, 0, 1};
        int gaddr [3] = '{200, 201, 202};
        for (int c = 0; c < 15; c++) begin
            if (c == 0) step(0, 0, 1, 200, 0);
            else if (c == 1) step(1, 201, 1, 202, 0);
            else if (c == 2) step(0, 0, 1, 202, 0);
            else step(0, 0, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                int   g;
                logic ev0;
                logic ev1;
                if (c < 3) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k]} !== ((gown[c] == 1) ? 2'b10 : 2'b01))
                        $display("FAIL fair_gnt k=%0d c=%0d: got %b", k, c, {gnt1_w[k], gnt0_w[k]});
                    else passed++;
                end
                g   = c - 2 - lat(k);
                ev0 = (g >= 0 && g < 3 && gown[g] == 0);
                ev1 = (g >= 0 && g < 3 && gown[g] == 1);
                checks++;
                if ({valid1_w[k], valid0_w[k]} !== {ev1, ev0})
                    $display("FAIL fair_valid k=%0d c=%0d: got %b expected %b", k, c,
                             {valid1_w[k], valid0_w[k]}, {ev1, ev0});
                else passed++;
                if (ev0 || ev1) begin
                    checks++;
                    if ((ev1 ? data1_w[k] : data0_w[k]) !== mem[gaddr[g]])
                        $display("FAIL fair_data k=%0d c=%0d: got %h expected %h", k, c,
                                 ev1 ? data1_w[k] : data0_w[k], mem[gaddr[g]]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 18; c++) begin
            if (c < 3) step(1, 10 + c, 0, 0, 0);
            else if (c == 3) step(1, 20, 0, 0, 1);
            else if (c == 4) step(1, 20, 0, 0, 0);
            else step(0, 0, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                if (c < 3 || c == 4) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k]} !== 2'b01)
                        $display("FAIL flush_gnt k=%0d c=%0d: got %b expected 01", k, c, {gnt1_w[k], gnt0_w[k]});
                    else passed++;
                end
                if (c == 3) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k], busy_w[k]} !== 3'b001)
                        $display("FAIL flush_hold k=%0d: got gnt %b busy %b expected 00/1", k,
                                 {gnt1_w[k], gnt0_w[k]}, busy_w[k]);
                    else passed++;
                end
                if (c == 4) begin
                    checks++;
                    if (busy_w[k] !== 1'b0)
                        $display("FAIL flush_busy k=%0d: got %b expected 0", k, busy_w[k]);
                    else passed++;
                end
                if (c >= 4) begin
                    checks++;
                    if ({valid1_w[k], valid0_w[k]} !== {1'b0, c == 6 + lat(k)})
                        $display("FAIL flush_valid k=%0d c=%0d: got %b", k, c, {valid1_w[k], valid0_w[k]});
                    else passed++;
                    if (c == 6 + lat(k)) begin
                        checks++;
                        if (data0_w[k] !== mem[20])
                            $display("FAIL flush_data k=%0d: got %h expected %h", k, data0_w[k], mem[20]);
                        else passed++;
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 300, 1, 400, 0);
        step(1, 300, 1, 400, 0);
        step(1, 300, 1, 400, 0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({mem_en_w[k], busy_w[k]} !== 2'b11)
                $display("FAIL areset_pre k=%0d: got en/busy %b expected 11", k, {mem_en_w[k], busy_w[k]});
            else passed++;
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({mem_en_w[k], valid0_w[k], valid1_w[k], busy_w[k], gnt0_w[k], gnt1_w[k]} !== 6'b0)
                $display("FAIL areset_now k=%0d: got %b expected 000000", k,
                         {mem_en_w[k], valid0_w[k], valid1_w[k], busy_w[k], gnt0_w[k], gnt1_w[k]});
            else passed++;
        end
        step(0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) step(1, 500, 1, 600, 0);
            else if (c == 1) step(0, 0, 1, 600, 0);
            else step(0, 0, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                if (c < 2) begin
                    checks++;
                    if ({gnt1_w[k], gnt0_w[k]} !== ((c == 0) ? 2'b01 : 2'b10))
                        $display("FAIL areset_gnt k=%0d c=%0d: got %b", k, c, {gnt1_w[k], gnt0_w[k]});
                    else passed++;
                end
                checks++;
                if ({valid1_w[k], valid0_w[k]} !== {c == 3 + lat(k), c == 2 + lat(k)})
                    $display("FAIL areset_valid k=%0d c=%0d: got %b", k, c, {valid1_w[k], valid0_w[k]});
                else passed++;
                if (c == 3 + lat(k)) begin
                    checks++;
                    if ({data0_w[k], data1_w[k]} !== {mem[500], mem[600]})
                        $display("FAIL areset_data k=%0d: got %h/%h expected %h/%h", k,
                                 data0_w[k], data1_w[k], mem[500], mem[600]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_random();
        logic       p0 = 1'b0;
        logic       p1 = 1'b0;
        int         a0 = 0;
        int         a1 = 0;
        int         f;
        logic [1:0] eg;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin p0 = 1'b1; a0 = $urandom_range(0, 1023); end
            if (!p1 && $urandom_range(0, 9) < 6) begin p1 = 1'b1; a1 = $urandom_range(0, 1023); end
            f = ($urandom_range(0, 29) == 0) ? 1 : 0;
            step(p0 ? 1 : 0, a0, p1 ? 1 : 0, a1, f);
            eg = rr_pick(p0, p1, f != 0, reset, rr_last);
            for (int k = 0; k < N; k++) begin
                logic eb;
                eb = 1'b0;
                foreach (q[i]) if (q[i].k == k) eb = 1'b1;
                checks++;
                if ({gnt1_w[k], gnt0_w[k]} !== eg)
                    $display("FAIL rnd_gnt k=%0d c=%0d: got %b expected %b", k, c, {gnt1_w[k], gnt0_w[k]}, eg);
                else passed++;
                checks++;
                if ({mem_en_w[k], mem_addr_w[k], busy_w[k]} !== {exp_mem_en, exp_mem_addr, eb})
                    $display("FAIL rnd_issue k=%0d c=%0d: got en %b addr %0d busy %b expected %b %0d %b", k, c,
                             mem_en_w[k], mem_addr_w[k], busy_w[k], exp_mem_en, exp_mem_addr, eb);
                else passed++;
                checks++;
                if ({valid0_w[k], valid1_w[k], data0_w[k], data1_w[k]} !== {exp_v0[k], exp_v1[k], exp_d0[k], exp_d1[k]})
                    $display("FAIL rnd_return k=%0d c=%0d: got v %b%b d %h/%h expected v %b%b d %h/%h", k, c,
                             valid0_w[k], valid1_w[k], data0_w[k], data1_w[k],
                             exp_v0[k], exp_v1[k], exp_d0[k], exp_d1[k]);
                else passed++;
            end
            if (eg[0]) p0 = 1'b0;
            if (eg[1]) p1 = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = EW'($urandom);
        mem[5] = 24'h00ABCD;
        test_reset();
        test_contention();
        test_single();
        test_fairness();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
